// File: rtl/vedic_div64x32_seq_if.sv
// Operand/result bundle for the sequential divider: two independent valid/ready channels.
// The master drives operands and result acceptance; the slave (divider) drives the rest.
interface vedic_div64x32_seq_if #(
  parameter int DW = 64,
  parameter int VW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dz
  );
endinterface

// File: rtl/vedic_div64x32_seq.sv
// Radix-2 restoring unsigned DW/VW divider, one quotient bit per clock; DW+1 edges latency, 1 for divide-by-zero.
// One op in flight: in_ready only in IDLE, result held in DONE until out_ready; no input queueing.
module vedic_div64x32_seq #(
  parameter int DW = 64,
  parameter int VW = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  vedic_div64x32_seq_if.slave  bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  state_t        state_nx;

  logic [DW-1:0] q_sh;
  logic [VW:0]   r;
  logic [VW-1:0] d;
  logic [CW-1:0] cnt;

  logic [VW:0]   t;
  logic [VW:0]   r_nx;
  logic          bit_nx;
  logic [DW-1:0] q_nx;
  logic          last_step;

  assign last_step = (cnt == CW'(DW - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = (bus.divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Partial remainder stays below d, so the shifted-in value fits in VW+1 bits.
  always_comb begin
    t      = {r[VW-1:0], q_sh[DW-1]};
    bit_nx = (t >= {1'b0, d});
    r_nx   = bit_nx ? (t - {1'b0, d}) : t;
    q_nx   = {q_sh[DW-2:0], bit_nx};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_sh          <= '0;
      r             <= '0;
      d             <= '0;
      cnt           <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.dz        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.divisor == '0) begin
              bus.quotient  <= '1;
              bus.remainder <= bus.dividend[VW-1:0];
              bus.dz        <= 1'b1;
            end else begin
              q_sh <= bus.dividend;
              r    <= '0;
              d    <= bus.divisor;
              cnt  <= '0;
            end
          end
        end
        CALC: begin
          q_sh <= q_nx;
          r    <= r_nx;
          cnt  <= cnt + 1'b1;
          if (last_step) begin
            bus.quotient  <= q_nx;
            bus.remainder <= r_nx[VW-1:0];
            bus.dz        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vedic_div64x32_seq.sv
// Scoreboard bench for the sequential divider: directed corner cases, mid-op reset, randomised traffic.
// Results are checked against native division and a 32x32 Vedic-multiplier reconstruction of the dividend.
module tb_vedic_div64x32_seq;
  localparam int DW = 64;
  localparam int VW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vedic_div64x32_seq_if #(.DW(DW), .VW(VW)) bus();

  vedic_div64x32_seq #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [63:0] a;
    logic [31:0] b;
    logic [63:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [95:0] mon_sum;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] vmul16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] ll, lh, hl, hh;
    ll = 16'(a[7:0])  * 16'(b[7:0]);
    lh = 16'(a[7:0])  * 16'(b[15:8]);
    hl = 16'(a[15:8]) * 16'(b[7:0]);
    hh = 16'(a[15:8]) * 16'(b[15:8]);
    return {16'b0, ll} + (({16'b0, lh} + {16'b0, hl}) << 8) + {hh, 16'b0};
  endfunction

  function automatic logic [63:0] vmul32(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ll, lh, hl, hh;
    ll = vmul16(a[15:0],  b[15:0]);
    lh = vmul16(a[15:0],  b[31:16]);
    hl = vmul16(a[31:16], b[15:0]);
    hh = vmul16(a[31:16], b[31:16]);
    return {32'b0, ll} + (({32'b0, lh} + {32'b0, hl}) << 16) + {hh, 32'b0};
  endfunction

  function automatic exp_t model(input logic [63:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] rr;
    e.a = a;
    e.b = b;
    if (b == 32'd0) begin
      e.q  = '1;
      e.r  = a[31:0];
      e.dz = 1'b1;
    end else begin
      e.q  = a / {32'b0, b};
      rr   = a % {32'b0, b};
      e.r  = rr[31:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: handshakes are decided by values stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("quotient", bus.quotient, mon_e.q);
          chk("remainder", bus.remainder, mon_e.r);
          chk("dz", bus.dz, mon_e.dz);
          if (!mon_e.dz) begin
            mon_sum = {32'b0, vmul32(bus.quotient[31:0], mon_e.b)}
                    + ({32'b0, vmul32(bus.quotient[63:32], mon_e.b)} << 32)
                    + {64'b0, bus.remainder};
            chk("invariant", mon_sum, {32'b0, mon_e.a});
            chk("rem_lt_div", (bus.remainder < mon_e.b), 1);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.dividend, bus.divisor));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [63:0] a, input logic [31:0] b);
    int g;
    g = 0;
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    while (!bus.in_ready && g < 2000) begin
      tick;
      @(negedge clk);
      g++;
    end
    chk("accept", bus.in_ready, 1);
    tick;
    bus.in_valid = 1'b0;
    bus.dividend = {$urandom, $urandom};
    bus.divisor  = $urandom;
  endtask

  task automatic measure(output int lat);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 200) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_quotient"}, bus.quotient, 0);
    chk({tag, "_remainder"}, bus.remainder, 0);
    chk({tag, "_dz"}, bus.dz, 0);
  endtask

  initial begin
    int lat;
    int g;
    logic [63:0] a;
    logic [31:0] b;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) tick;
    @(negedge clk);
    chk_reset_state("rst");
    tick;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    send(64'd100, 32'd7);
    measure(lat);
    chk("lat_100_7", lat, 65);
    chk("q_100_7", bus.quotient, 14);
    chk("r_100_7", bus.remainder, 2);
    chk("dz_100_7", bus.dz, 0);
    tick;

    send(64'hFFFF_FFFF_FFFF_FFFF, 32'd1);
    measure(lat);
    chk("q_max_1", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("r_max_1", bus.remainder, 0);
    tick;

    send(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
    measure(lat);
    chk("q_max_max", bus.quotient, 64'h1_0000_0001);
    chk("r_max_max", bus.remainder, 0);
    tick;

    send(64'd5, 32'd0);
    measure(lat);
    chk("lat_dz", lat, 1);
    chk("dz_5_0", bus.dz, 1);
    chk("q_5_0", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("r_5_0", bus.remainder, 5);
    tick;

    bus.out_ready = 1'b0;
    send(64'd3, 32'd10);
    measure(lat);
    chk("lat_3_10", lat, 65);
    for (int i = 0; i < 20; i++) begin
      chk("hold_q", bus.quotient, 0);
      chk("hold_r", bus.remainder, 3);
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      tick;
      @(negedge clk);
    end
    tick;
    bus.out_ready = 1'b1;
    @(negedge clk);
    tick;
    @(negedge clk);
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);
    tick;

    send(64'd12345678901, 32'd77);
    repeat (30) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    chk("midrst_sb", sb.size(), 0);
    tick;
    send(64'd100, 32'd7);
    measure(lat);
    chk("lat_after_rst", lat, 65);
    chk("q_after_rst", bus.quotient, 14);
    chk("r_after_rst", bus.remainder, 2);
    tick;

    rand_rdy = 1'b1;
    for (int i = 0; i < 600 && bad < 20; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      case ($urandom_range(0, 5))
        0: begin a = {$urandom, $urandom}; b = 32'd0; end
        1: begin a = {$urandom, $urandom}; b = $urandom_range(1, 15); end
        2: begin b = $urandom | 32'd1; a = {32'b0, 32'($urandom_range(0, b - 1))}; end
        3: begin a = {$urandom, $urandom}; b = 32'd1; end
        default: begin a = {$urandom, $urandom}; b = $urandom; end
      endcase
      send(a, b);
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    g = 0;
    @(negedge clk);
    while (sb.size() != 0 && g < 500) begin
      tick;
      @(negedge clk);
      g++;
    end
    chk("final_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
